// File: rtl/sd_sampler_n.sv
// sd_sampler_n: addressed discrete-input sampler with optional serial word
// assembly. A qualified sample latches one channel bit into DATA. In
// assembly mode the bits are also shifted MSB-first into a W-bit word that
// is handed to a consumer through a valid/ready pair, with a sticky overrun
// flag for words that complete while the previous one is still unconsumed.
module sd_sampler_n #(
   parameter int NCH = 14,
   parameter int W   = 8,
   localparam int AW = ($clog2(NCH) < 1) ? 1 : $clog2(NCH)
) (
   input  logic           SIM_CLK,
   input  logic           SIM_RST,
   input  logic           SMPL,
   input  logic           ADDRV,
   input  logic [AW-1:0]  ADDR,
   input  logic [NCH-1:0] CH_IN,
   input  logic           CLR,
   input  logic           MODE,
   input  logic           WORD_RDY,
   input  logic           OVR_CLR,
   output logic           DATA,
   output logic [W-1:0]   WORD,
   output logic           WORD_VLD,
   output logic           WORD_PAR,
   output logic           OVR
);

   // Count runs 0..W-1; the W-th bit completes the word and returns it to 0.
   localparam int CW = ($clog2(W) < 1) ? 1 : $clog2(W);

   typedef enum logic {
      DISC = 1'b0,
      ASM  = 1'b1
   } state_t;

   state_t         state;
   state_t         state_nx;
   logic           mreg;
   logic [CW-1:0]  cnt;
   logic [W-1:0]   shreg;
   logic [W-1:0]   sh_nx;
   logic           smp_bit;
   logic           acc;
   logic           mode_chg;
   logic           asm_shift;
   logic           done;
   logic           hs;
   logic           load;
   logic           ovr_set;

   function automatic logic par_of(input logic [W-1:0] v);
      return ^v;
   endfunction

   // Channel select; addresses at or beyond NCH read as 0.
   always_comb begin
      smp_bit = 1'b0;
      for (int k = 0; k < NCH; k++) begin
         if (ADDR == AW'(k)) smp_bit = CH_IN[k];
      end
   end

   // Qualify samples and decide what the word path does this cycle.
   always_comb begin
      acc       = SMPL & ADDRV;
      mode_chg  = (MODE != mreg);
      // A mode change or a clear wins over shifting: the sample reaches DATA only.
      asm_shift = (state == ASM) && !mode_chg && !CLR && acc;
      sh_nx     = {shreg[W-2:0], smp_bit};
      done      = asm_shift && (cnt == CW'(W - 1));
      hs        = WORD_VLD && WORD_RDY;
      // A word completing during a handshake replaces the consumed one.
      load      = done && (!WORD_VLD || WORD_RDY);
      ovr_set   = done && WORD_VLD && !WORD_RDY;
   end

   // Next-state logic: the FSM follows the registered mode.
   always_comb begin
      state_nx = state;
      if (mode_chg) state_nx = MODE ? ASM : DISC;
   end

   // State and mode registers.
   always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
      if (!SIM_RST) begin
         state <= DISC;
         mreg  <= 1'b0;
      end else begin
         state <= state_nx;
         mreg  <= MODE;
      end
   end

   // Latched sample bit: a sample beats a coincident clear.
   always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
      if (!SIM_RST) begin
         DATA <= 1'b0;
      end else if (acc) begin
         DATA <= smp_bit;
      end else if (CLR) begin
         DATA <= 1'b0;
      end
   end

   // Partial-word shift register and bit count.
   always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
      if (!SIM_RST) begin
         cnt   <= '0;
         shreg <= '0;
      end else if (mode_chg || (state != ASM) || CLR || done) begin
         cnt   <= '0;
         shreg <= '0;
      end else if (asm_shift) begin
         cnt   <= cnt + CW'(1);
         shreg <= sh_nx;
      end
   end

   // Completed-word holding register with valid/ready handoff.
   always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
      if (!SIM_RST) begin
         WORD     <= '0;
         WORD_VLD <= 1'b0;
         WORD_PAR <= 1'b0;
      end else if (load) begin
         WORD     <= sh_nx;
         WORD_VLD <= 1'b1;
         WORD_PAR <= par_of(sh_nx);
      end else if (hs) begin
         WORD_VLD <= 1'b0;
      end
   end

   // Sticky overrun: a new overrun outranks a coincident clear.
   always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
      if (!SIM_RST) begin
         OVR <= 1'b0;
      end else if (ovr_set) begin
         OVR <= 1'b1;
      end else if (OVR_CLR) begin
         OVR <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sd_sampler_n.sv
// Bench for sd_sampler_n: directed scenarios plus random traffic, checked
// through a scoreboard fed by a bit-list reference model.
module tb_sd_sampler_n;

   localparam int NCH = 14;
   localparam int W   = 8;
   localparam int AW  = 4;

   logic           SIM_CLK = 1'b0;
   logic           SIM_RST = 1'b0;
   logic           SMPL = 1'b0;
   logic           ADDRV = 1'b0;
   logic [AW-1:0]  ADDR = '0;
   logic [NCH-1:0] CH_IN = '0;
   logic           CLR = 1'b0;
   logic           MODE = 1'b0;
   logic           WORD_RDY = 1'b0;
   logic           OVR_CLR = 1'b0;
   logic           DATA;
   logic [W-1:0]   WORD;
   logic           WORD_VLD;
   logic           WORD_PAR;
   logic           OVR;

   sd_sampler_n #(.NCH(NCH), .W(W)) dut (
      .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST), .SMPL(SMPL), .ADDRV(ADDRV),
      .ADDR(ADDR), .CH_IN(CH_IN), .CLR(CLR), .MODE(MODE),
      .WORD_RDY(WORD_RDY), .OVR_CLR(OVR_CLR), .DATA(DATA), .WORD(WORD),
      .WORD_VLD(WORD_VLD), .WORD_PAR(WORD_PAR), .OVR(OVR)
   );

   always #5 SIM_CLK = ~SIM_CLK;

   typedef struct {
      logic         data;
      logic         vld;
      logic         ovr;
      logic         par;
      logic [W-1:0] word;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;

   // Reference model state: the partial word is a plain list of bits.
   bit           m_bits[$];
   bit           m_mode = 0;
   bit           m_data = 0;
   bit           m_vld  = 0;
   bit           m_ovr  = 0;
   bit           m_par  = 0;
   logic [W-1:0] m_word = '0;
   bit           cur_mode = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_bits.delete();
      m_mode = 0; m_data = 0; m_vld = 0; m_ovr = 0; m_par = 0; m_word = '0;
   endtask

   // One clock of stimulus; the model's post-edge state goes to the scoreboard.
   task automatic step(input bit smpl, input bit addrv, input logic [AW-1:0] addr,
                       input logic [NCH-1:0] ch, input bit clr, input bit mode,
                       input bit rdy, input bit oclr);
      bit   acc, b, hs, load, oset;
      int   w, ones;
      exp_t e;
      @(negedge SIM_CLK);
      SMPL = smpl; ADDRV = addrv; ADDR = addr; CH_IN = ch; CLR = clr;
      MODE = mode; WORD_RDY = rdy; OVR_CLR = oclr;
      acc  = smpl && addrv;
      b    = (int'(addr) < NCH) ? ch[addr] : 1'b0;
      hs   = m_vld && rdy;
      load = 0;
      oset = 0;
      if (mode != m_mode) begin
         m_bits.delete();
         m_mode = mode;
      end else if (m_mode) begin
         if (clr) m_bits.delete();
         else if (acc) begin
            m_bits.push_back(b);
            if (m_bits.size() == W) begin
               w = 0;
               ones = 0;
               foreach (m_bits[i]) begin
                  w = w * 2 + int'(m_bits[i]);
                  ones += int'(m_bits[i]);
               end
               if (!m_vld || rdy) begin
                  load   = 1;
                  m_word = w[W-1:0];
                  m_par  = bit'(ones % 2);
               end else begin
                  oset = 1;
               end
               m_bits.delete();
            end
         end
      end
      m_data = acc ? b : (clr ? 1'b0 : m_data);
      m_vld  = load ? 1'b1 : (hs ? 1'b0 : m_vld);
      m_ovr  = oset ? 1'b1 : (oclr ? 1'b0 : m_ovr);
      @(posedge SIM_CLK);
      e.data = m_data; e.vld = m_vld; e.ovr = m_ovr; e.par = m_par; e.word = m_word;
      exp_q.push_back(e);
      #1;
      SMPL = 0; ADDRV = 0; CLR = 0; WORD_RDY = 0; OVR_CLR = 0;
   endtask

   task automatic samp(input bit b, input bit rdy);
      step(1, 1, '0, {{(NCH-1){1'b0}}, b}, 0, cur_mode, rdy, 0);
   endtask

   task automatic word8(input logic [W-1:0] v, input bit rdy_last);
      for (int i = W - 1; i >= 0; i--) samp(v[i], (i == 0) ? rdy_last : 1'b0);
   endtask

   task automatic flush();
      int n = 0;
      while (exp_q.size() > 0 && n < 20) begin
         @(negedge SIM_CLK);
         n++;
      end
      #2;
      if (exp_q.size() > 0) chk("scoreboard_drain", exp_q.size(), 0);
   endtask

   // Monitor: compare each registered output set against the scoreboard.
   always @(negedge SIM_CLK) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("sb_data", DATA, e.data);
         chk("sb_word_vld", WORD_VLD, e.vld);
         chk("sb_ovr", OVR, e.ovr);
         chk("sb_word", WORD, e.word);
         chk("sb_word_par", WORD_PAR, e.par);
      end
   end

   initial begin
      // Reset state
      #1;
      chk("rst_data", DATA, 0);
      chk("rst_word", WORD, 0);
      chk("rst_vld", WORD_VLD, 0);
      chk("rst_ovr", OVR, 0);
      repeat (2) @(posedge SIM_CLK);
      #2 SIM_RST = 1;

      // Discrete sampling
      step(1, 1, 4'd13, 14'h2000, 0, 0, 0, 0);
      #2 chk("disc_ch13", DATA, 1);
      step(1, 0, 4'd13, 14'h0000, 0, 0, 0, 0);
      #2 chk("disc_addrv0_hold", DATA, 1);
      step(1, 1, 4'd15, 14'h3FFF, 0, 0, 0, 0);
      #2 chk("disc_addr15", DATA, 0);
      step(1, 1, 4'd2, 14'h0004, 0, 0, 0, 0);
      step(0, 0, 4'd0, 14'h0000, 1, 0, 0, 0);
      #2 chk("disc_clr", DATA, 0);
      step(1, 1, 4'd2, 14'h0004, 1, 0, 0, 0);
      #2 chk("disc_clr_vs_smpl", DATA, 1);

      // Word assembly
      cur_mode = 1;
      step(0, 0, '0, '0, 0, 1, 0, 0);
      word8(8'hB2, 0);
      #2 chk("word_b2", WORD, 8'hB2);
      chk("word_b2_vld", WORD_VLD, 1);
      chk("word_b2_par", WORD_PAR, 0);

      // Overrun
      word8(8'h3C, 0);
      #2 chk("ovr_word_kept", WORD, 8'hB2);
      chk("ovr_set", OVR, 1);
      step(0, 0, '0, '0, 0, 1, 0, 1);
      #2 chk("ovr_clr", OVR, 0);

      // Completion coincident with handshake
      word8(8'h5D, 1);
      #2 chk("hs_word", WORD, 8'h5D);
      chk("hs_vld", WORD_VLD, 1);
      chk("hs_ovr", OVR, 0);
      chk("hs_par", WORD_PAR, 1);

      // CLR mid-word
      step(0, 0, '0, '0, 0, 1, 1, 0);
      samp(1, 0); samp(1, 0); samp(1, 0);
      step(0, 0, '0, '0, 1, 1, 0, 0);
      word8(8'h0F, 0);
      #2 chk("clr_word", WORD, 8'h0F);

      // Mode toggle mid-word
      step(0, 0, '0, '0, 0, 1, 1, 0);
      samp(1, 0); samp(1, 0); samp(1, 0);
      cur_mode = 0; step(0, 0, '0, '0, 0, 0, 0, 0);
      cur_mode = 1; step(0, 0, '0, '0, 0, 1, 0, 0);
      word8(8'h21, 0);
      #2 chk("mode_word", WORD, 8'h21);

      // Random traffic
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 39) == 0) cur_mode = ~cur_mode;
         step(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 4) != 0),
              AW'($urandom_range(0, 15)), NCH'($urandom), bit'($urandom_range(0, 19) == 0),
              cur_mode, bit'($urandom_range(0, 2) == 0), bit'($urandom_range(0, 29) == 0));
      end

      // Asynchronous reset mid-word with a word pending
      cur_mode = 1;
      step(0, 0, '0, '0, 0, 1, 1, 0);
      step(0, 0, '0, '0, 0, 1, 0, 0);
      word8(8'hA7, 0);
      samp(1, 0); samp(0, 0); samp(1, 0);
      #2 chk("pre_rst_vld", WORD_VLD, 1);
      flush();
      SIM_RST = 0;
      #1;
      chk("arst_data", DATA, 0);
      chk("arst_word", WORD, 0);
      chk("arst_vld", WORD_VLD, 0);
      chk("arst_par", WORD_PAR, 0);
      chk("arst_ovr", OVR, 0);
      model_reset();
      @(negedge SIM_CLK);
      #2 SIM_RST = 1;
      step(0, 0, '0, '0, 0, 1, 0, 0);
      word8(8'h96, 0);
      #2 chk("post_rst_word", WORD, 8'h96);

      flush();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
